// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings and constants for the PC / fetch-control stage.
// Holds the FSM state encoding, the sequential PC step and the default reset PC.
package pc_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   localparam int unsigned PC_INC       = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_next_mux.sv
// Next-PC priority select: branch > jump > hold > sequential.
// Purely combinational; enable/state gating is applied by the PC register in the top.
module pc_next_mux #(
   parameter int unsigned NB_PC = 32
) (
   input  logic [NB_PC-1:0] pc_i,
   input  logic [NB_PC-1:0] pc_plus4_i,
   input  logic             branch_i,
   input  logic [NB_PC-1:0] branch_target_i,
   input  logic             jump_i,
   input  logic [NB_PC-1:0] jump_target_i,
   input  logic             hold_i,
   output logic [NB_PC-1:0] pc_next_o
);

   always_comb begin
      pc_next_o = pc_plus4_i;
      if (branch_i)
         pc_next_o = branch_target_i;
      else if (jump_i)
         pc_next_o = jump_target_i;
      else if (hold_i)
         pc_next_o = pc_i;
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch-control FSM (RUN/DRAIN/HALTED), redirect flush and
// enabled-cycle counter for the instruction-fetch stage.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int unsigned      NB_PC        = 32,
   parameter logic [NB_PC-1:0] RESET_PC     = NB_PC'(RESET_PC_DEF),
   parameter int unsigned      DRAIN_CYCLES = 4,
   parameter int unsigned      NB_CNT       = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_pc_source,
   input  logic [NB_PC-1:0]  i_branch_target,
   input  logic              i_jump,
   input  logic [NB_PC-1:0]  i_jump_target,
   input  logic              i_stall,
   input  logic              i_halt_detect,
   output logic [NB_PC-1:0]  o_pc,
   output logic [NB_PC-1:0]  o_pc_plus4,
   output logic              o_flush,
   output logic              o_halted,
   output logic [NB_CNT-1:0] o_cycle_count
);

   localparam int unsigned          NB_DRN     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [NB_DRN-1:0]    DRAIN_LOAD = NB_DRN'(DRAIN_CYCLES - 1);

   fetch_state_e      state_q;
   logic [NB_PC-1:0]  pc_q, pc_d;
   logic [NB_DRN-1:0] drain_q;
   logic [NB_CNT-1:0] cnt_q;
   logic              halted_q;
   logic              redirect;
   logic              hold;

   assign redirect      = i_enable & (i_pc_source | i_jump);
   assign o_flush       = redirect & (state_q != ST_HALTED);
   assign o_pc          = pc_q;
   assign o_pc_plus4    = pc_q + NB_PC'(PC_INC);
   assign o_halted      = halted_q;
   assign o_cycle_count = cnt_q;

   // Outside RUN the PC only moves on a redirect; a halt in RUN parks fetch on the HALT.
   assign hold = (state_q != ST_RUN) | i_stall | i_halt_detect;

   pc_next_mux #(.NB_PC(NB_PC)) u_next_mux (
      .pc_i            (pc_q),
      .pc_plus4_i      (o_pc_plus4),
      .branch_i        (i_pc_source),
      .branch_target_i (i_branch_target),
      .jump_i          (i_jump),
      .jump_target_i   (i_jump_target),
      .hold_i          (hold),
      .pc_next_o       (pc_d)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         drain_q  <= '0;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else if (i_enable && state_q != ST_HALTED) begin
         pc_q <= pc_d;
         if (cnt_q != '1)
            cnt_q <= cnt_q + NB_CNT'(1);
         case (state_q)
            ST_RUN: begin
               if (!redirect && !i_stall && i_halt_detect) begin
                  state_q <= ST_DRAIN;
                  drain_q <= DRAIN_LOAD;
               end
            end
            ST_DRAIN: begin
               // A redirect here means the HALT was fetched down a wrong path.
               if (redirect)
                  state_q <= ST_RUN;
               else if (drain_q == '0) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end else
                  drain_q <= drain_q - NB_DRN'(1);
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized
// run, all checked against a behavioural model of the fetch-control rules.
module tb_pc_fetch_ctrl;

   localparam int DRAIN = 4;

   logic        i_clk = 1'b0;
   logic        i_reset, i_enable, i_pc_source, i_jump, i_stall, i_halt_detect;
   logic [31:0] i_branch_target, i_jump_target;
   logic [31:0] o_pc, o_pc_plus4, o_cycle_count;
   logic        o_flush, o_halted;

   pc_fetch_ctrl #(.NB_PC(32), .RESET_PC(32'h0), .DRAIN_CYCLES(DRAIN), .NB_CNT(32)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_pc_source(i_pc_source),
      .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
      .i_stall(i_stall), .i_halt_detect(i_halt_detect), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4),
      .o_flush(o_flush), .o_halted(o_halted), .o_cycle_count(o_cycle_count)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: PC, whether we are draining, cycles left until halt.
   logic [31:0] m_pc, m_cnt;
   bit          m_draining, m_halted;
   int          m_left;
   logic        exp_flush, obs_flush;

   task automatic model_reset();
      m_pc = 32'h0; m_cnt = 32'h0; m_draining = 0; m_halted = 0; m_left = 0;
   endtask

   task automatic model_step(input logic en, ps, input logic [31:0] bt, input logic j,
                             input logic [31:0] jt, input logic st, hd);
      bit redirect;
      redirect  = en && (ps || j);
      exp_flush = redirect && !m_halted;
      if (m_halted || !en) return;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (redirect) begin
         m_pc = ps ? bt : jt;
         m_draining = 0;
      end else if (m_draining) begin
         m_left = m_left - 1;
         if (m_left == 0) begin m_halted = 1; m_draining = 0; end
      end else if (st) begin
         // stall: hold
      end else if (hd) begin
         m_draining = 1;
         m_left = DRAIN;
      end else
         m_pc = m_pc + 4;
   endtask

   task automatic apply(input logic en, ps, input logic [31:0] bt, input logic j,
                        input logic [31:0] jt, input logic st, hd);
      i_enable = en; i_pc_source = ps; i_branch_target = bt;
      i_jump = j; i_jump_target = jt; i_stall = st; i_halt_detect = hd;
      #1;
      obs_flush = o_flush;
      model_step(en, ps, bt, j, jt, st, hd);
      @(posedge i_clk); #1;
   endtask

   task automatic idle();
      i_enable = 0; i_pc_source = 0; i_jump = 0; i_stall = 0; i_halt_detect = 0;
      i_branch_target = 0; i_jump_target = 0;
   endtask

   // Reset is asserted with random other inputs to show it overrides them.
   task automatic do_reset();
      i_reset = 1;
      i_enable = 1'($urandom); i_pc_source = 1'($urandom); i_jump = 1'($urandom);
      i_stall = 1'($urandom); i_halt_detect = 1'($urandom);
      i_branch_target = $urandom; i_jump_target = $urandom;
      @(posedge i_clk); #1;
      i_reset = 0;
      idle();
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_vec++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", o_pc, 32'h0); end
      n_vec++; if (o_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc4: got %h want %h", o_pc_plus4, 32'h4); end
      n_vec++; if (o_flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", o_flush); end
      n_vec++; if (o_halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", o_halted); end
      n_vec++; if (o_cycle_count !== 32'h0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_cycle_count); end
   endtask

   task automatic test_sequential();
      for (int k = 1; k <= 3; k++) begin
         apply(1, 0, 0, 0, 0, 0, 0);
         n_vec++; if (obs_flush !== 1'b0) begin n_err++; $display("FAIL seq_flush: got %b want 0", obs_flush); end
         n_vec++; if (o_pc !== 32'(4 * k)) begin n_err++; $display("FAIL seq_pc: got %h want %h", o_pc, 32'(4 * k)); end
      end
      n_vec++; if (o_cycle_count !== 32'd3) begin n_err++; $display("FAIL seq_count: got %0d want 3", o_cycle_count); end
   endtask

   task automatic test_branch_vs_stall();
      apply(1, 0, 0, 0, 0, 0, 0);  // PC 0x0C -> 0x10
      n_vec++; if (o_pc !== 32'h10) begin n_err++; $display("FAIL bvs_setup: got %h want %h", o_pc, 32'h10); end
      apply(1, 1, 32'h40, 0, 0, 1, 0);
      n_vec++; if (obs_flush !== 1'b1) begin n_err++; $display("FAIL bvs_flush: got %b want 1", obs_flush); end
      n_vec++; if (o_pc !== 32'h40) begin n_err++; $display("FAIL bvs_pc: got %h want %h", o_pc, 32'h40); end
      apply(1, 0, 0, 1, 32'h10, 0, 0);
      apply(1, 0, 0, 0, 0, 1, 0);
      n_vec++; if (o_pc !== 32'h10) begin n_err++; $display("FAIL stall_hold: got %h want %h", o_pc, 32'h10); end
      n_vec++; if (obs_flush !== 1'b0) begin n_err++; $display("FAIL stall_flush: got %b want 0", obs_flush); end
      n_vec++; if (o_cycle_count !== m_cnt) begin n_err++; $display("FAIL stall_count: got %0d want %0d", o_cycle_count, m_cnt); end
   endtask

   task automatic test_branch_vs_jump();
      apply(1, 1, 32'h80, 1, 32'hC0, 0, 0);
      n_vec++; if (obs_flush !== 1'b1) begin n_err++; $display("FAIL bvj_flush: got %b want 1", obs_flush); end
      n_vec++; if (o_pc !== 32'h80) begin n_err++; $display("FAIL bvj_pc: got %h want %h", o_pc, 32'h80); end
      apply(1, 0, 0, 1, 32'hC0, 0, 0);
      n_vec++; if (o_pc !== 32'hC0) begin n_err++; $display("FAIL jump_pc: got %h want %h", o_pc, 32'hC0); end
   endtask

   task automatic test_halt();
      logic [31:0] cnt_at_halt;
      apply(1, 0, 0, 1, 32'h20, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 1);   // HALT sampled here (edge N)
      for (int k = 1; k <= DRAIN; k++) begin
         n_vec++; if (o_halted !== 1'b0) begin n_err++; $display("FAIL halt_early: cycle %0d got %b want 0", k, o_halted); end
         n_vec++; if (o_pc !== 32'h20) begin n_err++; $display("FAIL halt_pc: got %h want %h", o_pc, 32'h20); end
         apply(1, 0, 0, 0, 0, 0, 0);
      end
      n_vec++; if (o_halted !== 1'b1) begin n_err++; $display("FAIL halt_rise: got %b want 1", o_halted); end
      n_vec++; if (o_halted !== logic'(m_halted)) begin n_err++; $display("FAIL halt_model: got %b want %b", o_halted, m_halted); end
      cnt_at_halt = m_cnt;
      for (int k = 0; k < 3; k++) begin
         apply(1, 1, 32'h300, 1, 32'h400, 0, 0);
         n_vec++; if (obs_flush !== 1'b0) begin n_err++; $display("FAIL halted_flush: got %b want 0", obs_flush); end
         n_vec++; if (o_pc !== 32'h20) begin n_err++; $display("FAIL halted_pc: got %h want %h", o_pc, 32'h20); end
      end
      n_vec++; if (o_cycle_count !== cnt_at_halt) begin n_err++; $display("FAIL halted_count: got %0d want %0d", o_cycle_count, cnt_at_halt); end
      do_reset();
      n_vec++; if (o_halted !== 1'b0 || o_pc !== 32'h0) begin n_err++; $display("FAIL halt_exit: got halted=%b pc=%h want 0/0", o_halted, o_pc); end
   endtask

   task automatic test_wrong_path();
      apply(1, 0, 0, 0, 0, 0, 1);   // enter DRAIN at PC 0
      apply(1, 0, 0, 0, 0, 0, 0);   // 1st DRAIN cycle
      apply(1, 1, 32'h100, 0, 0, 0, 0);  // 2nd DRAIN cycle: branch
      n_vec++; if (obs_flush !== 1'b1) begin n_err++; $display("FAIL wp_flush: got %b want 1", obs_flush); end
      n_vec++; if (o_pc !== 32'h100) begin n_err++; $display("FAIL wp_pc: got %h want %h", o_pc, 32'h100); end
      for (int k = 0; k < DRAIN + 1; k++) apply(1, 0, 0, 0, 0, 0, 0);
      n_vec++; if (o_halted !== 1'b0) begin n_err++; $display("FAIL wp_halted: got %b want 0", o_halted); end
      n_vec++; if (o_pc !== m_pc) begin n_err++; $display("FAIL wp_run: got %h want %h", o_pc, m_pc); end
   endtask

   task automatic test_step_wrap();
      logic [31:0] pc0, cnt0;
      pc0 = m_pc; cnt0 = m_cnt;
      for (int p = 1; p <= 3; p++) begin
         apply(1, 0, 0, 0, 0, 0, 0);
         for (int k = 0; k < 4; k++) apply(0, 0, 0, 0, 0, 0, 0);
         n_vec++; if (o_pc !== pc0 + 32'(4 * p)) begin n_err++; $display("FAIL step_pc: got %h want %h", o_pc, pc0 + 32'(4 * p)); end
         n_vec++; if (o_cycle_count !== cnt0 + 32'(p)) begin n_err++; $display("FAIL step_count: got %0d want %0d", o_cycle_count, cnt0 + 32'(p)); end
      end
      apply(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
      n_vec++; if (o_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want %h", o_pc_plus4, 32'h0); end
      apply(1, 0, 0, 0, 0, 0, 0);
      n_vec++; if (o_pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want %h", o_pc, 32'h0); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 99) < 3) begin
            do_reset();
            continue;
         end
         apply(logic'($urandom_range(0, 99) < 75), logic'($urandom_range(0, 99) < 12),
               $urandom & 32'hFFFF_FFFC, logic'($urandom_range(0, 99) < 12),
               $urandom & 32'hFFFF_FFFC, logic'($urandom_range(0, 99) < 20),
               logic'($urandom_range(0, 99) < 10));
         n_vec++;
         if (obs_flush !== exp_flush || o_pc !== m_pc || o_pc_plus4 !== m_pc + 32'd4 ||
             o_halted !== logic'(m_halted) || o_cycle_count !== m_cnt) begin
            n_err++;
            $display("FAIL rand[%0d]: got flush=%b pc=%h pc4=%h halted=%b cnt=%0d want %b %h %h %b %0d",
                     k, obs_flush, o_pc, o_pc_plus4, o_halted, o_cycle_count,
                     exp_flush, m_pc, m_pc + 32'd4, m_halted, m_cnt);
         end
      end
   endtask

   initial begin
      i_reset = 0;
      idle();
      model_reset();
      test_reset();
      test_sequential();
      test_branch_vs_stall();
      test_branch_vs_jump();
      test_halt();
      test_wrong_path();
      test_step_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
